// File: rtl/gf163_inverter.sv
// GF(2^163) inverter, poly x^163 + x^80 + x^47 + x^9 + 1.
// Computes a^(2^163-2) by alternating square and multiply on one shared combinational multiplier.
module karatsuba163 (
    input  logic [162:0] a,
    input  logic [162:0] b,
    output logic [162:0] p
);
    function automatic logic [162:0] clmul82(input logic [81:0] x, input logic [81:0] y);
        logic [162:0] acc;
        acc = 163'd0;
        for (int i = 0; i < 82; i++) begin
            if (y[i]) acc = acc ^ ({81'd0, x} << i);
            else      acc = acc;
        end
        return acc;
    endfunction

    // Fold every coefficient at or above x^163 back through the pentanomial.
    function automatic logic [162:0] reduce(input logic [324:0] c_in);
        logic [324:0] c;
        c = c_in;
        for (int i = 324; i >= 163; i--) begin
            if (c[i]) begin
                c[i]       = 1'b0;
                c[i - 83]  = c[i - 83]  ^ 1'b1;
                c[i - 116] = c[i - 116] ^ 1'b1;
                c[i - 154] = c[i - 154] ^ 1'b1;
                c[i - 163] = c[i - 163] ^ 1'b1;
            end else begin
                c[i] = 1'b0;
            end
        end
        return c[162:0];
    endfunction

    logic [81:0]  a_lo_s, b_lo_s, a_hi_s, b_hi_s;
    logic [162:0] ll_s, hh_s, mid_s;
    logic [324:0] full_s;

    // One Karatsuba level: three half-width carry-less products, then reduction.
    always_comb begin
        a_lo_s = a[81:0];
        b_lo_s = b[81:0];
        a_hi_s = {1'b0, a[162:82]};
        b_hi_s = {1'b0, b[162:82]};
        ll_s   = clmul82(a_lo_s, b_lo_s);
        hh_s   = clmul82(a_hi_s, b_hi_s);
        mid_s  = clmul82(a_lo_s ^ a_hi_s, b_lo_s ^ b_hi_s) ^ ll_s ^ hh_s;
        full_s = {162'd0, ll_s} ^ ({162'd0, mid_s} << 82) ^ ({162'd0, hh_s} << 164);
        p      = reduce(full_s);
    end
endmodule

module gf163_inverter #(
    parameter int M    = 163,
    parameter int ITER = 162
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] a,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] result
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SQR  = 2'd1,
        MUL  = 2'd2
    } state_t;

    state_t       state_r, next_state_s;
    logic [M-1:0] s_r, r_r, result_r, op_a_s, op_b_s, prod_s;
    logic [7:0]   cnt_r;
    logic         busy_r, done_r, last_s;

    karatsuba163 u_mul (
        .a (op_a_s),
        .b (op_b_s),
        .p (prod_s)
    );

    assign last_s = (cnt_r == 8'(ITER - 1));
    assign busy   = busy_r;
    assign done   = done_r;
    assign result = result_r;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_r <= IDLE;
        else     state_r <= next_state_s;
    end

    // Next-state logic.
    always_comb begin
        next_state_s = IDLE;
        case (state_r)
            IDLE:    next_state_s = start ? SQR : IDLE;
            SQR:     next_state_s = MUL;
            MUL:     next_state_s = last_s ? IDLE : SQR;
            default: next_state_s = IDLE;
        endcase
    end

    // Operand mux; IDLE squares s because the product is unused there.
    always_comb begin
        op_a_s = s_r;
        op_b_s = s_r;
        case (state_r)
            IDLE:    begin op_a_s = s_r; op_b_s = s_r; end
            SQR:     begin op_a_s = s_r; op_b_s = s_r; end
            MUL:     begin op_a_s = r_r; op_b_s = s_r; end
            default: begin op_a_s = s_r; op_b_s = s_r; end
        endcase
    end

    // Datapath and registered status outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            s_r      <= {M{1'b0}};
            r_r      <= {M{1'b0}};
            cnt_r    <= 8'd0;
            result_r <= {M{1'b0}};
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        s_r    <= a;
                        r_r    <= {{(M-1){1'b0}}, 1'b1};
                        cnt_r  <= 8'd0;
                        busy_r <= 1'b1;
                    end
                end
                SQR: s_r <= prod_s;
                MUL: begin
                    if (last_s) begin
                        result_r <= prod_s;
                        done_r   <= 1'b1;
                        busy_r   <= 1'b0;
                    end else begin
                        r_r   <= prod_s;
                        cnt_r <= cnt_r + 8'd1;
                    end
                end
                default: begin
                    busy_r <= 1'b0;
                end
            endcase
        end
    end
endmodule
